// File: rtl/fwd_prop_engine.sv
// rtl/fwd_prop_engine.sv - forward-propagation sequencer: MMU reads, fixed-point MAC, activation, write-back
module fwd_prop_engine #(
  parameter int DW = 16,
  parameter int FRAC = 8,
  parameter int AW = 16,
  parameter int N_LAYERS = 4,
  parameter int N = 8,
  parameter logic [AW-1:0] DATA_BASE = 16'h0000,
  parameter logic [AW-1:0] WEIGHT_BASE = 16'h0100,
  parameter logic [AW-1:0] BIAS_BASE = 16'h0200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N_LAYERS-1:0] act_sel,
  output logic                  mmu_valid,
  output logic                  mmu_we,
  output logic [AW-1:0]         mmu_address,
  output logic [DW-1:0]         mmu_wdata,
  input  logic                  mmu_ready,
  input  logic [DW-1:0]         mmu_data,
  output logic                  activate_valid,
  output logic [DW-1:0]         activate_in,
  output logic [1:0]            activate_ctrl,
  input  logic                  activate_ready,
  input  logic [DW-1:0]         activate_out,
  output logic                  busy,
  output logic                  done
);

  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = 2*DW + $clog2(N) + 1;
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_B, RD_X, RD_W, SAT, ACT, WR, DONE} state_t;

  state_t                  state;
  logic [LW-1:0]           l;
  logic [IW-1:0]           j;
  logic [IW-1:0]           i;
  logic signed [DW-1:0]    x_reg;
  logic signed [ACCW-1:0]  acc;
  logic signed [2*DW-1:0]  prod;
  logic [ACCW-1:0]         prod_ext;
  logic [ACCW-1:0]         bias_ext;
  logic signed [ACCW-1:0]  acc_sh;
  logic [DW-1:0]           sat_val;

  function automatic logic [AW-1:0] x_addr(input logic [LW-1:0] ll, input logic [IW-1:0] ii);
    return DATA_BASE + AW'(ll) * AW'(N) + AW'(ii);
  endfunction

  function automatic logic [AW-1:0] w_addr(input logic [LW-1:0] ll, input logic [IW-1:0] jj,
                                          input logic [IW-1:0] ii);
    return WEIGHT_BASE + AW'(ll) * AW'(N*N) + AW'(jj) * AW'(N) + AW'(ii);
  endfunction

  function automatic logic [AW-1:0] b_addr(input logic [LW-1:0] ll, input logic [IW-1:0] jj);
    return BIAS_BASE + AW'(ll) * AW'(N) + AW'(jj);
  endfunction

  function automatic logic [AW-1:0] o_addr(input logic [LW-1:0] ll, input logic [IW-1:0] jj);
    return DATA_BASE + (AW'(ll) + AW'(1)) * AW'(N) + AW'(jj);
  endfunction

  // Bias is pre-scaled to the 2*FRAC product scale so the accumulator holds one fixed-point format.
  always_comb begin
    prod     = x_reg * $signed(mmu_data);
    prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACCW-DW-FRAC){mmu_data[DW-1]}}, mmu_data, {FRAC{1'b0}}};
    acc_sh   = acc >>> FRAC;
    sat_val  = acc_sh[DW-1:0];
    if (acc_sh > SAT_MAX) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (acc_sh < SAT_MIN) begin
      sat_val = SAT_MIN[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      l              <= '0;
      j              <= '0;
      i              <= '0;
      x_reg          <= '0;
      acc            <= '0;
      mmu_valid      <= 1'b0;
      mmu_we         <= 1'b0;
      mmu_address    <= '0;
      mmu_wdata      <= '0;
      activate_valid <= 1'b0;
      activate_in    <= '0;
      activate_ctrl  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            l           <= '0;
            j           <= '0;
            i           <= '0;
            busy        <= 1'b1;
            mmu_valid   <= 1'b1;
            mmu_we      <= 1'b0;
            mmu_address <= b_addr('0, '0);
            state       <= RD_B;
          end
        end
        RD_B: begin
          if (mmu_ready) begin
            acc         <= bias_ext;
            mmu_address <= x_addr(l, i);
            state       <= RD_X;
          end
        end
        RD_X: begin
          if (mmu_ready) begin
            x_reg       <= $signed(mmu_data);
            mmu_address <= w_addr(l, j, i);
            state       <= RD_W;
          end
        end
        RD_W: begin
          if (mmu_ready) begin
            acc <= acc + prod_ext;
            if (i == IW'(N-1)) begin
              i         <= '0;
              mmu_valid <= 1'b0;
              state     <= SAT;
            end else begin
              i           <= i + IW'(1);
              mmu_address <= x_addr(l, i + IW'(1));
              state       <= RD_X;
            end
          end
        end
        SAT: begin
          activate_in    <= sat_val;
          activate_ctrl  <= act_sel[{l, 1'b0} +: 2];
          activate_valid <= 1'b1;
          state          <= ACT;
        end
        ACT: begin
          if (activate_ready) begin
            activate_valid <= 1'b0;
            mmu_valid      <= 1'b1;
            mmu_we         <= 1'b1;
            mmu_address    <= o_addr(l, j);
            mmu_wdata      <= activate_out;
            state          <= WR;
          end
        end
        WR: begin
          if (mmu_ready) begin
            mmu_we <= 1'b0;
            if (j != IW'(N-1)) begin
              j           <= j + IW'(1);
              mmu_address <= b_addr(l, j + IW'(1));
              state       <= RD_B;
            end else if (l != LW'(N_LAYERS-1)) begin
              j           <= '0;
              l           <= l + LW'(1);
              mmu_address <= b_addr(l + LW'(1), '0);
              state       <= RD_B;
            end else begin
              mmu_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_prop_engine.sv
// tb/tb_fwd_prop_engine.sv - table vectors plus scoreboarded MMU/activation responders for fwd_prop_engine
module tb_fwd_prop_engine;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NL = 2;
  localparam int N = 2;
  localparam int WB = 16'h0100;
  localparam int BB = 16'h0200;
  localparam int PASS_CYC = NL*N*(2*N+4) + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*NL-1:0] act_sel;
  logic          mmu_valid, mmu_we, mmu_ready;
  logic [AW-1:0] mmu_address;
  logic [DW-1:0] mmu_wdata, mmu_data;
  logic          activate_valid, activate_ready;
  logic [DW-1:0] activate_in, activate_out;
  logic [1:0]    activate_ctrl;
  logic          busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit stall_en = 0;
  bit hold_w = 0;

  logic [15:0] mem [0:1023];

  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } mreq_t;
  typedef struct { logic [1:0] ctrl; logic [15:0] din; } areq_t;
  mreq_t mq[$];
  areq_t aq[$];

  typedef struct {
    logic [15:0] x0, x1, w00, w01, w10, w11, b0, b1;
    logic [7:0]  sel;
    logic [15:0] e0, e1;
  } vec_t;

  fwd_prop_engine #(.DW(DW), .FRAC(8), .AW(AW), .N_LAYERS(NL), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .act_sel(act_sel),
    .mmu_valid(mmu_valid), .mmu_we(mmu_we), .mmu_address(mmu_address), .mmu_wdata(mmu_wdata),
    .mmu_ready(mmu_ready), .mmu_data(mmu_data),
    .activate_valid(activate_valid), .activate_in(activate_in), .activate_ctrl(activate_ctrl),
    .activate_ready(activate_ready), .activate_out(activate_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in activation unit: piecewise-linear sigmoid/tanh, ReLU, identity.
  function automatic int act_fn(input logic [1:0] c, input int v);
    int t;
    case (c)
      2'b00: begin t = (v >>> 2) + 128; if (t < 0) t = 0; if (t > 256) t = 256; end
      2'b01: begin t = v; if (t < -256) t = -256; if (t > 256) t = 256; end
      2'b10: t = (v < 0) ? 0 : v;
      default: t = v;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] rnd16();
    int r;
    r = $urandom_range(0, 1023) - 512;
    return r[15:0];
  endfunction

  task automatic build_expect(input logic [7:0] sel);
    int dm [0:(NL+1)*N-1];
    longint acc, s;
    int y;
    logic [1:0] c;
    for (int k = 0; k < N; k++) dm[k] = $signed(mem[k]);
    for (int l = 0; l < NL; l++) begin
      for (int j = 0; j < N; j++) begin
        mq.push_back('{1'b0, 16'(BB + l*N + j), 16'h0});
        acc = longint'($signed(mem[BB + l*N + j])) * 256;
        for (int i = 0; i < N; i++) begin
          mq.push_back('{1'b0, 16'(l*N + i), 16'h0});
          mq.push_back('{1'b0, 16'(WB + l*N*N + j*N + i), 16'h0});
          acc += longint'(dm[l*N + i]) * longint'($signed(mem[WB + l*N*N + j*N + i]));
        end
        s = acc >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        c = sel[2*l +: 2];
        aq.push_back('{c, 16'(s)});
        y = act_fn(c, int'(s));
        dm[(l+1)*N + j] = y;
        mq.push_back('{1'b1, 16'((l+1)*N + j), 16'(y)});
      end
    end
  endtask

  task automatic load_vec(input vec_t v);
    mem[0] = v.x0; mem[1] = v.x1;
    mem[WB+0] = v.w00; mem[WB+1] = v.w01; mem[WB+2] = v.w10; mem[WB+3] = v.w11;
    mem[BB+0] = v.b0; mem[BB+1] = v.b1;
    for (int k = 4; k < 8; k++) mem[WB+k] = rnd16();
    mem[BB+2] = rnd16(); mem[BB+3] = rnd16();
    for (int k = 2; k < 6; k++) mem[k] = 16'h0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 5000; k++) begin
      if (done) begin d = cyc; break; end
      @(negedge clk);
    end
    if (d < 0) chk("done_seen", done, 1);
    else chk("busy_low_at_done", busy, 0);
  endtask

  task automatic run_pass(input bit timed);
    int s, d;
    build_expect(act_sel);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    wait_done(d);
    if (timed && d >= 0) chk("pass_cycles", d - s + 1, PASS_CYC);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("mmu_queue_drained", mq.size(), 0);
    chk("act_queue_drained", aq.size(), 0);
  endtask

  // MMU and activation responders; each accepted transfer is checked against the scoreboard.
  initial begin
    int m_cnt, a_cnt;
    bit m_pend, a_pend, m_prev, a_prev;
    logic [33:0] prev_m;
    logic [18:0] prev_a;
    mreq_t e;
    areq_t ea;
    int r;
    m_cnt = 0; a_cnt = 0; m_pend = 0; a_pend = 0; m_prev = 0; a_prev = 0;
    prev_m = '0; prev_a = '0;
    mmu_ready = 0; mmu_data = 0; activate_ready = 0; activate_out = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 0; a_pend = 0; m_prev = 0; a_prev = 0;
        mmu_ready = 0; activate_ready = 0;
      end else begin
        if (m_prev) chk("mmu_stable_in_stall", {mmu_valid, mmu_we, mmu_address, mmu_wdata}, prev_m);
        if (a_prev) chk("act_stable_in_stall", {activate_valid, activate_ctrl, activate_in}, prev_a);
        if (activate_valid) chk("no_mmu_valid_in_act", mmu_valid, 0);
        mmu_ready = 0;
        if (mmu_valid) begin
          if (!m_pend) begin m_pend = 1; m_cnt = stall_en ? $urandom_range(0, 5) : 0; end
          mmu_data = mem[mmu_address[9:0]];
          if (m_cnt == 0 && !(hold_w && !mmu_we && mmu_address >= 16'h0100 && mmu_address < 16'h0200)) begin
            mmu_ready = 1; m_pend = 0;
            chk("mmu_expected", mq.size() != 0, 1);
            if (mq.size() != 0) begin
              e = mq.pop_front();
              chk("mmu_we", mmu_we, e.we);
              chk("mmu_address", mmu_address, e.addr);
              if (e.we) chk("mmu_wdata", mmu_wdata, e.data);
            end
            if (mmu_we) mem[mmu_address[9:0]] = mmu_wdata;
          end else if (m_cnt > 0) begin
            m_cnt--;
          end
        end
        activate_ready = 0;
        if (activate_valid) begin
          if (!a_pend) begin a_pend = 1; a_cnt = stall_en ? $urandom_range(0, 5) : 0; end
          r = act_fn(activate_ctrl, int'($signed(activate_in)));
          activate_out = r[15:0];
          if (a_cnt == 0) begin
            activate_ready = 1; a_pend = 0;
            chk("act_expected", aq.size() != 0, 1);
            if (aq.size() != 0) begin
              ea = aq.pop_front();
              chk("activate_ctrl", activate_ctrl, ea.ctrl);
              chk("activate_in", activate_in, ea.din);
            end
          end else begin
            a_cnt--;
          end
        end
        m_prev = mmu_valid && !mmu_ready;
        prev_m = {mmu_valid, mmu_we, mmu_address, mmu_wdata};
        a_prev = activate_valid && !activate_ready;
        prev_a = {activate_valid, activate_ctrl, activate_in};
      end
    end
  end

  initial begin
    vec_t tbl [5];
    int s, d;
    bit hit;
    tbl[0] = '{16'h0100, 16'h0200, 16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0080, 16'h0000, 8'hFF, 16'h0380, 16'h0100};
    tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 8'hFF, 16'h7FFF, 16'h7FFF};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 8'hFF, 16'h8000, 16'h8000};
    tbl[3] = '{16'hFFFF, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'hFF80, 16'h0000, 16'h0000, 8'hFF, 16'hFFFF, 16'hFF80};
    tbl[4] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 8'b0000_0110, 16'h0000, 16'h0080};
    for (int k = 0; k < 1024; k++) mem[k] = 16'h0;
    rst = 1'b1; start = 1'b0; act_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_mmu_outputs", {mmu_valid, mmu_we, mmu_address, mmu_wdata}, 0);
    chk("rst_act_outputs", {activate_valid, activate_ctrl, activate_in}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      load_vec(tbl[t]);
      act_sel = tbl[t].sel;
      run_pass(1);
      chk("tbl_layer0_out0", mem[2], tbl[t].e0);
      chk("tbl_layer0_out1", mem[3], tbl[t].e1);
    end

    stall_en = 1;
    for (int p = 0; p < 4; p++) begin
      load_vec('{rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 8'h00, 16'h0, 16'h0});
      act_sel = 4'($urandom_range(0, 15));
      run_pass(0);
    end
    stall_en = 0;

    // Starts while busy and in the done cycle are ignored; a start the cycle after done runs again.
    load_vec(tbl[0]);
    act_sel = 4'hF;
    build_expect(act_sel);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      start = (k % 7 == 3);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(d);
    if (d >= 0) chk("busy_starts_ignored_cycles", d - s + 1, PASS_CYC);
    start = 1'b1;
    @(negedge clk);
    build_expect(act_sel);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("second_pass_busy", busy, 1);
    wait_done(d);
    if (d >= 0) chk("second_pass_cycles", d - s + 1, PASS_CYC);
    repeat (4) @(negedge clk);
    chk("single_pass_idle", {busy, mmu_valid}, 0);
    chk("single_pass_queue", mq.size(), 0);
    chk("second_pass_out0", mem[2], 16'h0380);
    chk("second_pass_out1", mem[3], 16'h0100);

    // Reset while stalled in a weight read.
    load_vec('{rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 8'h00, 16'h0, 16'h0});
    act_sel = 4'b0110;
    build_expect(act_sel);
    hold_w = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      if (mmu_valid && !mmu_we && mmu_address >= 16'h0100 && mmu_address < 16'h0200) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("reached_rd_w_stall", hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("midpass_rst_mmu", {mmu_valid, mmu_we, mmu_address, mmu_wdata}, 0);
    chk("midpass_rst_act", {activate_valid, activate_ctrl, activate_in}, 0);
    chk("midpass_rst_busy_done", {busy, done}, 0);
    mq.delete();
    aq.delete();
    hold_w = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
